// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder backed by an internal word-addressed SRAM array.
// One transaction in flight; byte-strobed writes, latency-configurable reads, SLVERR on out-of-range writes.
module axi_lite_sram_slave #(
   parameter int                   BUS_WIDTH    = 32,
   parameter int                   DATA_WIDTH   = 32,
   parameter int                   ADDR_BITS    = 12,
   parameter logic [BUS_WIDTH-1:0] BASE_ADDR    = 32'h8000_0000,
   parameter int                   READ_LATENCY = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ar_valid,
   output logic                    ar_ready,
   input  logic [BUS_WIDTH-1:0]    ar_addr,
   input  logic [2:0]              ar_prot,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [BUS_WIDTH-1:0]    aw_addr,
   input  logic [2:0]              aw_prot,
   output logic                    rd_valid,
   input  logic                    rd_ready,
   output logic [DATA_WIDTH-1:0]   rd_data,
   input  logic                    wd_valid,
   output logic                    wd_ready,
   input  logic [DATA_WIDTH-1:0]   wd_data,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   output logic                    wr_valid,
   input  logic                    wr_ready,
   output logic [1:0]              wr_breap
);
   localparam int                   STRB_W = DATA_WIDTH / 8;
   localparam logic [BUS_WIDTH-1:0] SPAN   = BUS_WIDTH'(64'd4 << ADDR_BITS);
   localparam logic [1:0]           OKAY   = 2'b00;
   localparam logic [1:0]           SLVERR = 2'b10;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WR_COLLECT = 3'd1;
   localparam logic [2:0] WR_RESP    = 3'd2;
   localparam logic [2:0] RD_WAIT    = 3'd3;
   localparam logic [2:0] RD_RESP    = 3'd4;

   logic [2:0]             state;
   logic                   have_aw;
   logic                   have_wd;
   logic [BUS_WIDTH-1:0]   aw_q;
   logic [BUS_WIDTH-1:0]   ar_q;
   logic [DATA_WIDTH-1:0]  wd_q;
   logic [STRB_W-1:0]      wstrb_q;
   logic [7:0]             cnt;
   logic [DATA_WIDTH-1:0]  mem [2**ADDR_BITS];

   logic                   aw_hs;
   logic                   wd_hs;
   logic                   ar_hs;
   logic                   commit;
   logic [BUS_WIDTH-1:0]   w_addr;
   logic [DATA_WIDTH-1:0]  w_data;
   logic [STRB_W-1:0]      w_strb;
   logic [BUS_WIDTH-1:0]   w_off;
   logic [BUS_WIDTH-1:0]   r_off;
   logic                   w_in;
   logic                   r_in;
   logic [ADDR_BITS-1:0]   w_idx;
   logic [ADDR_BITS-1:0]   r_idx;
   logic                   unused;

   always_comb begin
      aw_ready = 1'b0;
      wd_ready = 1'b0;
      ar_ready = 1'b0;
      if (!reset) begin
         case (state)
            IDLE: begin
               aw_ready = 1'b1;
               wd_ready = 1'b1;
               ar_ready = !aw_valid && !wd_valid;
            end
            WR_COLLECT: begin
               aw_ready = !have_aw;
               wd_ready = !have_wd;
            end
            default: ;
         endcase
      end
   end

   assign aw_hs  = aw_valid && aw_ready;
   assign wd_hs  = wd_valid && wd_ready;
   assign ar_hs  = ar_valid && ar_ready;
   // In WR_COLLECT only the missing half is ready, so any handshake completes the pair.
   assign commit = (state == IDLE) ? (aw_hs && wd_hs)
                                   : ((state == WR_COLLECT) && (aw_hs || wd_hs));

   assign w_addr = have_aw ? aw_q    : aw_addr;
   assign w_data = have_wd ? wd_q    : wd_data;
   assign w_strb = have_wd ? wstrb_q : wstrb;

   assign w_off  = w_addr - BASE_ADDR;
   assign r_off  = ar_q - BASE_ADDR;
   assign w_in   = w_off < SPAN;
   assign r_in   = r_off < SPAN;
   assign w_idx  = w_off[ADDR_BITS+1:2];
   assign r_idx  = r_off[ADDR_BITS+1:2];
   assign unused = ^{ar_prot, aw_prot, w_off[1:0], r_off[1:0]};

   always_ff @(posedge clk) begin
      if (commit && w_in) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (w_strb[i]) mem[w_idx][i*8 +: 8] <= w_data[i*8 +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         have_aw  <= 1'b0;
         have_wd  <= 1'b0;
         aw_q     <= '0;
         wd_q     <= '0;
         wstrb_q  <= '0;
         ar_q     <= '0;
         cnt      <= '0;
         rd_data  <= '0;
         wr_breap <= OKAY;
      end else begin
         case (state)
            IDLE: begin
               if (commit) begin
                  wr_breap <= w_in ? OKAY : SLVERR;
                  state    <= WR_RESP;
               end else if (aw_hs) begin
                  have_aw <= 1'b1;
                  aw_q    <= aw_addr;
                  state   <= WR_COLLECT;
               end else if (wd_hs) begin
                  have_wd <= 1'b1;
                  wd_q    <= wd_data;
                  wstrb_q <= wstrb;
                  state   <= WR_COLLECT;
               end else if (ar_hs) begin
                  ar_q  <= ar_addr;
                  cnt   <= 8'(READ_LATENCY);
                  state <= RD_WAIT;
               end
            end
            WR_COLLECT: begin
               if (commit) begin
                  wr_breap <= w_in ? OKAY : SLVERR;
                  have_aw  <= 1'b0;
                  have_wd  <= 1'b0;
                  state    <= WR_RESP;
               end
            end
            WR_RESP: if (wr_ready) state <= IDLE;
            // One RD_WAIT cycle is always spent as the array read; cnt adds the extra waits.
            RD_WAIT: begin
               if (cnt == 8'd0) begin
                  rd_data <= r_in ? mem[r_idx] : '0;
                  state   <= RD_RESP;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            RD_RESP: if (rd_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign rd_valid = (state == RD_RESP);
   assign wr_valid = (state == WR_RESP);
endmodule
